// File: rtl/sc_instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: field widths, opcodes,
// ALU select codes, state encodings, idle control word and flag positions.
package sc_instr_sequencer_pkg;

  localparam int DATAWIDTH_DECODER_SELECTION    = 3;
  localparam int DATAWIDTH_MUX_SELECTION        = 3;
  localparam int DATAWIDTH_ALU_SELECTION        = 4;
  localparam int DATAWIDTH_REGSHIFTER_SELECTION = 2;
  localparam int DATAWIDTH_OPCODE               = 4;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_NOTA = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_SHL  = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_NOTA = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_INC  = 4'b1010;
  localparam logic [3:0] ALU_DEC  = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // Idle control word: nothing selected, shifter holding its value
  localparam logic [2:0] IDLE_DECODER = 3'b111;
  localparam logic [2:0] IDLE_MUX     = 3'b111;
  localparam logic [3:0] IDLE_ALU     = 4'b1111;
  localparam logic       IDLE_LOAD    = 1'b1;
  localparam logic [1:0] IDLE_SHIFT   = 2'b11;

  localparam logic [1:0] SHIFT_LEFT   = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT  = 2'b10;

  // Highest legal destination register and highest legal source select
  localparam logic [2:0] MAX_DST = 3'd3;
  localparam logic [2:0] MAX_SRC = 3'd5;

  // Bit positions of {V,C,N,Z} inside the latched flag vector
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/sc_instr_decode.sv
// Combinational instruction decode: maps the opcode onto an ALU select code,
// classifies it (unary, shift direction, NOP) and flags illegal instructions.
module sc_instr_decode
  import sc_instr_sequencer_pkg::*;
(
  input  logic [DATAWIDTH_OPCODE-1:0]               opcode,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    dst,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        src_a,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        src_b,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        alu_sel,
  output logic                                      unary,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] shift_sel,
  output logic                                      nop,
  output logic                                      illegal
);

  logic op_legal;

  // Opcode table; SrcA is used by every non-NOP op, SrcB only by binary ops
  always_comb begin
    alu_sel   = IDLE_ALU;
    unary     = 1'b0;
    shift_sel = IDLE_SHIFT;
    nop       = 1'b0;
    op_legal  = 1'b1;
    case (opcode)
      OP_NOP:  nop = 1'b1;
      OP_MOV:  begin alu_sel = ALU_PASS; unary = 1'b1; end
      OP_OR:   alu_sel = ALU_OR;
      OP_AND:  alu_sel = ALU_AND;
      OP_NOTA: begin alu_sel = ALU_NOTA; unary = 1'b1; end
      OP_XOR:  alu_sel = ALU_XOR;
      OP_ADD:  alu_sel = ALU_ADD;
      OP_SUB:  alu_sel = ALU_SUB;
      OP_INC:  begin alu_sel = ALU_INC; unary = 1'b1; end
      OP_DEC:  begin alu_sel = ALU_DEC; unary = 1'b1; end
      OP_SHL:  begin alu_sel = ALU_PASS; unary = 1'b1; shift_sel = SHIFT_LEFT; end
      OP_SHR:  begin alu_sel = ALU_PASS; unary = 1'b1; shift_sel = SHIFT_RIGHT; end
      default: op_legal = 1'b0;
    endcase
    illegal = !op_legal
           || (dst > MAX_DST)
           || (!nop && (src_a > MAX_SRC))
           || (!nop && !unary && (src_b > MAX_SRC));
  end

endmodule

// File: rtl/sc_instr_sequencer.sv
// Instruction-level sequencer: accepts one register-to-register instruction
// per handshake and expands it into read / load / shift / write-back control.
module sc_instr_sequencer
  import sc_instr_sequencer_pkg::*;
(
  input  logic                                      SC_INSTRSEQ_CLOCK_50,
  input  logic                                      SC_INSTRSEQ_Reset_InHigh,
  input  logic                                      SC_INSTRSEQ_InstrValid_InHigh,
  input  logic [DATAWIDTH_OPCODE-1:0]               SC_INSTRSEQ_InstrOpcode_In,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_INSTRSEQ_InstrDst_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_INSTRSEQ_InstrSrcA_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_INSTRSEQ_InstrSrcB_In,
  input  logic                                      SC_INSTRSEQ_Overflow_InLow,
  input  logic                                      SC_INSTRSEQ_Carry_InLow,
  input  logic                                      SC_INSTRSEQ_Negative_InLow,
  input  logic                                      SC_INSTRSEQ_Zero_InLow,
  output logic                                      SC_INSTRSEQ_InstrReady_OutHigh,
  output logic                                      SC_INSTRSEQ_Done_OutHigh,
  output logic                                      SC_INSTRSEQ_Error_OutHigh,
  output logic [3:0]                                SC_INSTRSEQ_Flags_Out,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_INSTRSEQ_DecoderSelectionWrite_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_INSTRSEQ_MUXSelectionBUSA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_INSTRSEQ_MUXSelectionBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_INSTRSEQ_ALUSelection_Out,
  output logic                                      SC_INSTRSEQ_RegSHIFTERLoad_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_INSTRSEQ_RegSHIFTERShiftSelection_OutLow
);

  state_t state;

  logic [DATAWIDTH_ALU_SELECTION-1:0]        dec_alu_sel;
  logic                                      dec_unary;
  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] dec_shift_sel;
  logic                                      dec_nop;
  logic                                      dec_illegal;

  logic [DATAWIDTH_DECODER_SELECTION-1:0]    lat_dst;
  logic [DATAWIDTH_MUX_SELECTION-1:0]        lat_src_a;
  logic [DATAWIDTH_MUX_SELECTION-1:0]        lat_src_b;
  logic [DATAWIDTH_ALU_SELECTION-1:0]        lat_alu_sel;
  logic                                      lat_unary;
  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] lat_shift_sel;
  logic                                      lat_write_en;
  logic                                      lat_illegal;
  logic [3:0]                                flags_reg;

  // Decode the incoming fields so the IDLE state can pick the next state and
  // latch the classification together with the raw fields.
  sc_instr_decode u_decode (
    .opcode    (SC_INSTRSEQ_InstrOpcode_In),
    .dst       (SC_INSTRSEQ_InstrDst_In),
    .src_a     (SC_INSTRSEQ_InstrSrcA_In),
    .src_b     (SC_INSTRSEQ_InstrSrcB_In),
    .alu_sel   (dec_alu_sel),
    .unary     (dec_unary),
    .shift_sel (dec_shift_sel),
    .nop       (dec_nop),
    .illegal   (dec_illegal)
  );

  // State register, instruction field latches and flag capture at the end of LOAD
  always_ff @(posedge SC_INSTRSEQ_CLOCK_50 or posedge SC_INSTRSEQ_Reset_InHigh) begin
    if (SC_INSTRSEQ_Reset_InHigh) begin
      state         <= ST_IDLE;
      lat_dst       <= '0;
      lat_src_a     <= '0;
      lat_src_b     <= '0;
      lat_alu_sel   <= '0;
      lat_unary     <= 1'b0;
      lat_shift_sel <= '0;
      lat_write_en  <= 1'b0;
      lat_illegal   <= 1'b0;
      flags_reg     <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (SC_INSTRSEQ_InstrValid_InHigh) begin
            lat_dst       <= SC_INSTRSEQ_InstrDst_In;
            lat_src_a     <= SC_INSTRSEQ_InstrSrcA_In;
            lat_src_b     <= SC_INSTRSEQ_InstrSrcB_In;
            lat_alu_sel   <= dec_alu_sel;
            lat_unary     <= dec_unary;
            lat_shift_sel <= dec_shift_sel;
            lat_write_en  <= !dec_illegal && !dec_nop;
            lat_illegal   <= dec_illegal;
            state         <= (dec_illegal || dec_nop) ? ST_WRITE : ST_READ;
          end
        end
        ST_READ:  state <= ST_LOAD;
        ST_LOAD: begin
          flags_reg[FLAG_V] <= !SC_INSTRSEQ_Overflow_InLow;
          flags_reg[FLAG_C] <= !SC_INSTRSEQ_Carry_InLow;
          flags_reg[FLAG_N] <= !SC_INSTRSEQ_Negative_InLow;
          flags_reg[FLAG_Z] <= !SC_INSTRSEQ_Zero_InLow;
          state <= (lat_shift_sel != IDLE_SHIFT) ? ST_SHIFT : ST_WRITE;
        end
        ST_SHIFT: state <= ST_WRITE;
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Control word decode from state and latched fields; idle word unless overridden
  always_comb begin
    SC_INSTRSEQ_InstrReady_OutHigh              = 1'b0;
    SC_INSTRSEQ_Done_OutHigh                    = 1'b0;
    SC_INSTRSEQ_Error_OutHigh                   = 1'b0;
    SC_INSTRSEQ_DecoderSelectionWrite_Out       = IDLE_DECODER;
    SC_INSTRSEQ_MUXSelectionBUSA_Out            = IDLE_MUX;
    SC_INSTRSEQ_MUXSelectionBUSB_Out            = IDLE_MUX;
    SC_INSTRSEQ_ALUSelection_Out                = IDLE_ALU;
    SC_INSTRSEQ_RegSHIFTERLoad_OutLow           = IDLE_LOAD;
    SC_INSTRSEQ_RegSHIFTERShiftSelection_OutLow = IDLE_SHIFT;
    case (state)
      ST_IDLE: SC_INSTRSEQ_InstrReady_OutHigh = 1'b1;
      ST_READ, ST_LOAD: begin
        SC_INSTRSEQ_MUXSelectionBUSA_Out  = lat_src_a;
        SC_INSTRSEQ_MUXSelectionBUSB_Out  = lat_unary ? IDLE_MUX : lat_src_b;
        SC_INSTRSEQ_ALUSelection_Out      = lat_alu_sel;
        SC_INSTRSEQ_RegSHIFTERLoad_OutLow = (state == ST_READ);
      end
      ST_SHIFT: SC_INSTRSEQ_RegSHIFTERShiftSelection_OutLow = lat_shift_sel;
      ST_WRITE: begin
        if (lat_write_en) SC_INSTRSEQ_DecoderSelectionWrite_Out = lat_dst;
        SC_INSTRSEQ_Done_OutHigh  = !lat_illegal;
        SC_INSTRSEQ_Error_OutHigh = lat_illegal;
      end
      default: ;
    endcase
  end

  assign SC_INSTRSEQ_Flags_Out = flags_reg;

endmodule

// File: tb/tb_sc_instr_sequencer.sv
// Self-checking bench for sc_instr_sequencer: each scenario task pushes the
// expected per-cycle control word to a scoreboard queue and compares it
// against the DUT outputs sampled on the falling clock edge.
module tb_sc_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic [2:0] dst = 3'b000;
  logic [2:0] src_a = 3'b000;
  logic [2:0] src_b = 3'b000;
  logic [3:0] flags_low = 4'b1111;

  logic       ready, done, error, load_low;
  logic [3:0] flags, alu;
  logic [2:0] decoder, busa, busb;
  logic [1:0] shift;

  logic [22:0] observed;
  logic [22:0] exp_q[$];
  logic [3:0]  model_flags;
  int          errors = 0;
  int          checks = 0;

  sc_instr_sequencer dut (
    .SC_INSTRSEQ_CLOCK_50                        (clk),
    .SC_INSTRSEQ_Reset_InHigh                    (rst),
    .SC_INSTRSEQ_InstrValid_InHigh               (valid),
    .SC_INSTRSEQ_InstrOpcode_In                  (opcode),
    .SC_INSTRSEQ_InstrDst_In                     (dst),
    .SC_INSTRSEQ_InstrSrcA_In                    (src_a),
    .SC_INSTRSEQ_InstrSrcB_In                    (src_b),
    .SC_INSTRSEQ_Overflow_InLow                  (flags_low[3]),
    .SC_INSTRSEQ_Carry_InLow                     (flags_low[2]),
    .SC_INSTRSEQ_Negative_InLow                  (flags_low[1]),
    .SC_INSTRSEQ_Zero_InLow                      (flags_low[0]),
    .SC_INSTRSEQ_InstrReady_OutHigh              (ready),
    .SC_INSTRSEQ_Done_OutHigh                    (done),
    .SC_INSTRSEQ_Error_OutHigh                   (error),
    .SC_INSTRSEQ_Flags_Out                       (flags),
    .SC_INSTRSEQ_DecoderSelectionWrite_Out       (decoder),
    .SC_INSTRSEQ_MUXSelectionBUSA_Out            (busa),
    .SC_INSTRSEQ_MUXSelectionBUSB_Out            (busb),
    .SC_INSTRSEQ_ALUSelection_Out                (alu),
    .SC_INSTRSEQ_RegSHIFTERLoad_OutLow           (load_low),
    .SC_INSTRSEQ_RegSHIFTERShiftSelection_OutLow (shift)
  );

  always #5 clk = ~clk;

  // Packed view {ready,done,error,decoder,busa,busb,alu,load,shift,flags}
  assign observed = {ready, done, error, decoder, busa, busb, alu, load_low, shift, flags};

  function automatic logic [22:0] mk(input logic rdy, input logic dn, input logic er,
                                     input logic [2:0] dec, input logic [2:0] ba,
                                     input logic [2:0] bb, input logic [3:0] al,
                                     input logic ld, input logic [1:0] sh,
                                     input logic [3:0] fl);
    return {rdy, dn, er, dec, ba, bb, al, ld, sh, fl};
  endfunction

  // Reference opcode table
  function automatic void model_op(input logic [3:0] op, output logic legal_op,
                                   output logic [3:0] al, output logic unary,
                                   output logic [1:0] sh, output logic nop);
    legal_op = 1'b1; al = 4'b1111; unary = 1'b0; sh = 2'b11; nop = 1'b0;
    case (op)
      4'b0000: nop = 1'b1;
      4'b0001: begin al = 4'b0000; unary = 1'b1; end
      4'b0010: al = 4'b0001;
      4'b0011: al = 4'b0010;
      4'b0100: begin al = 4'b0011; unary = 1'b1; end
      4'b0101: al = 4'b0100;
      4'b1000: al = 4'b1000;
      4'b1001: al = 4'b1001;
      4'b1010: begin al = 4'b1010; unary = 1'b1; end
      4'b1011: begin al = 4'b1011; unary = 1'b1; end
      4'b1100: begin al = 4'b0000; unary = 1'b1; sh = 2'b01; end
      4'b1101: begin al = 4'b0000; unary = 1'b1; sh = 2'b10; end
      default: legal_op = 1'b0;
    endcase
  endfunction

  // Push the expected word for every cycle after acceptance, ending with the
  // IDLE cycle in which the sequencer is ready again
  task automatic push_expected(input logic [3:0] op, input logic [2:0] d,
                               input logic [2:0] a, input logic [2:0] b,
                               input logic [3:0] fl_low);
    logic legal_op, unary, nop, illegal;
    logic [3:0] al;
    logic [1:0] sh;
    logic [2:0] bb;
    model_op(op, legal_op, al, unary, sh, nop);
    illegal = !legal_op || (d > 3'd3) || (!nop && a > 3'd5) || (!nop && !unary && b > 3'd5);
    if (illegal || nop) begin
      exp_q.push_back(mk(1'b0, !illegal, illegal, 3'b111, 3'b111, 3'b111, 4'b1111, 1'b1, 2'b11, model_flags));
    end else begin
      bb = unary ? 3'b111 : b;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, a, bb, al, 1'b1, 2'b11, model_flags));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, a, bb, al, 1'b0, 2'b11, model_flags));
      model_flags = ~fl_low;
      if (sh != 2'b11)
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 3'b111, 3'b111, 4'b1111, 1'b1, sh, model_flags));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, d, 3'b111, 3'b111, 4'b1111, 1'b1, 2'b11, model_flags));
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 3'b111, 3'b111, 3'b111, 4'b1111, 1'b1, 2'b11, model_flags));
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic [3:0] fl_low);
    opcode = op; dst = d; src_a = a; src_b = b; flags_low = fl_low;
  endtask

  // Pop and compare one scoreboard entry per falling edge until empty
  task automatic drain(input string name);
    logic [22:0] expected;
    int cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      expected = exp_q.pop_front();
      checks++;
      if (observed !== expected) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, observed, expected);
      end
    end
  endtask

  task automatic check_ready(input string name);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ready before issue: got %b expected 1", name, ready);
    end
  endtask

  task automatic run_instr(input string name, input logic [3:0] op, input logic [2:0] d,
                           input logic [2:0] a, input logic [2:0] b, input logic [3:0] fl_low);
    @(negedge clk);
    drive(op, d, a, b, fl_low);
    valid = 1'b1;
    check_ready(name);
    push_expected(op, d, a, b, fl_low);
    @(posedge clk);
    #1 valid = 1'b0;
    drain(name);
  endtask

  // Reset word, then a NOP held valid across reset release
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (observed !== mk(1'b1, 1'b0, 1'b0, 3'b111, 3'b111, 3'b111, 4'b1111, 1'b1, 2'b11, 4'b0000)) begin
      errors++;
      $display("[TB] FAIL reset_word: got %b expected idle word with ready", observed);
    end
    model_flags = 4'b0000;
    drive(4'b0000, 3'b000, 3'b000, 3'b000, 4'b1111);
    valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_ready("nop_after_reset");
    push_expected(4'b0000, 3'b000, 3'b000, 3'b000, 4'b1111);
    @(posedge clk);
    #1 valid = 1'b0;
    drain("nop_after_reset");
  endtask

  task automatic test_mov();
    run_instr("mov", 4'b0001, 3'b010, 3'b101, 3'b111, 4'b1111);
  endtask

  task automatic test_shr();
    run_instr("shr", 4'b1101, 3'b011, 3'b011, 3'b000, 4'b0111);
  endtask

  task automatic test_add_flags();
    run_instr("add", 4'b1000, 3'b001, 3'b000, 3'b011, 4'b1010);
  endtask

  task automatic test_illegal();
    run_instr("illegal_opcode", 4'b0111, 3'b000, 3'b000, 3'b000, 4'b0000);
    run_instr("illegal_dst", 4'b1000, 3'b100, 3'b000, 3'b001, 4'b0000);
    run_instr("illegal_srcb", 4'b0101, 3'b000, 3'b001, 3'b110, 4'b0000);
  endtask

  // Valid held high across two ALU ops; the second must wait for IDLE
  task automatic test_back_to_back();
    logic [22:0] expected;
    int n = 0;
    @(negedge clk);
    drive(4'b0010, 3'b000, 3'b001, 3'b010, 4'b0110);
    valid = 1'b1;
    check_ready("b2b");
    push_expected(4'b0010, 3'b000, 3'b001, 3'b010, 4'b0110);
    push_expected(4'b1001, 3'b011, 3'b101, 3'b100, 4'b0110);
    @(posedge clk);
    #1 drive(4'b1001, 3'b011, 3'b101, 3'b100, 4'b0110);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      expected = exp_q.pop_front();
      checks++;
      if (observed !== expected) begin
        errors++;
        $display("[TB] FAIL b2b cycle %0d: got %b expected %b", n, observed, expected);
      end
      if (n == 4) begin
        @(posedge clk);
        #1 valid = 1'b0;
      end
    end
  endtask

  // Reset asserted while a SHL sits in SHIFT
  task automatic test_reset_mid_shift();
    logic [22:0] expected;
    logic [22:0] idle_word;
    idle_word = mk(1'b1, 1'b0, 1'b0, 3'b111, 3'b111, 3'b111, 4'b1111, 1'b1, 2'b11, 4'b0000);
    @(negedge clk);
    drive(4'b1100, 3'b010, 3'b100, 3'b000, 4'b0000);
    valid = 1'b1;
    check_ready("shl_reset");
    push_expected(4'b1100, 3'b010, 3'b100, 3'b000, 4'b0000);
    @(posedge clk);
    #1 valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      expected = exp_q.pop_front();
      checks++;
      if (observed !== expected) begin
        errors++;
        $display("[TB] FAIL shl_reset cycle %0d: got %b expected %b", i, observed, expected);
      end
    end
    exp_q.delete();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (observed !== idle_word) begin
      errors++;
      $display("[TB] FAIL reset_mid_shift: got %b expected %b", observed, idle_word);
    end
    model_flags = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (observed !== idle_word) begin
        errors++;
        $display("[TB] FAIL after_reset_idle %0d: got %b expected %b", i, observed, idle_word);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mov();
    test_shr();
    test_add_flags();
    test_illegal();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

endmodule
